// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencing controller.
// Op codes follow the hilo_bus op_type field; state encoding is 2 bits.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_MUL_WAIT = 2'b01,
    S_DIV_WAIT = 2'b10,
    S_DONE     = 2'b11
  } state_e;

  localparam logic [1:0]  HILO_WE_BOTH = 2'b11;
  localparam logic [1:0]  HILO_WE_NONE = 2'b00;
  localparam logic [31:0] DIV0_LO      = 32'hFFFF_FFFF;

  // Pipeline-control and divider handshake levels.
  localparam logic STOP      = 1'b1;
  localparam logic NO_STOP   = 1'b0;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  function automatic logic op_is_div(op_e op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequences one MULT/MULTU/DIV/DIVU per EX instruction: holds operands, waits out the
// multiplier latency or the divider handshake, stalls EX, then writes HI/LO exactly once.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_type,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        ex_advance,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed,
  input  logic [63:0] mul_result,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  output logic        div_signed,
  output logic        div_start,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stallreq,
  output logic        busy,
  output logic [1:0]  hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned        CNT_W    = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  op_e              op_in;

  assign op_in = op_e'(op_type);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stallreq  = NO_STOP;
    div_start = DIV_STOP;
    div_annul = 1'b0;
    hilo_we   = HILO_WE_NONE;

    if (rst) begin
      state_d = S_IDLE;
    end else if (flush) begin
      state_d   = S_IDLE;
      div_annul = (state_q == S_DIV_WAIT);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            stallreq = STOP;
            op_d     = op_in;
            opa_d    = src_a;
            opb_d    = src_b;
            if (!op_is_div(op_in)) begin
              cnt_d   = CNT_INIT;
              state_d = S_MUL_WAIT;
            end else if (src_b != '0) begin
              state_d = S_DIV_WAIT;
            end else begin
              // Divide by zero never reaches the divider; the result is fixed.
              hi_d    = src_a;
              lo_d    = DIV0_LO;
              state_d = S_DONE;
            end
          end
        end
        S_MUL_WAIT: begin
          stallreq = STOP;
          cnt_d    = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            hi_d    = mul_result[63:32];
            lo_d    = mul_result[31:0];
            state_d = S_DONE;
          end
        end
        S_DIV_WAIT: begin
          stallreq = STOP;
          if (div_ready) begin
            hi_d    = div_result[63:32];
            lo_d    = div_result[31:0];
            state_d = S_DONE;
          end else begin
            div_start = DIV_START;
          end
        end
        S_DONE: begin
          // Hold the result until EX actually advances so HI/LO is written once.
          if (ex_advance) begin
            hilo_we = HILO_WE_BOTH;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULTU;
      opa_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign mul_a      = opa_q;
  assign mul_b      = opb_q;
  assign mul_signed = (op_q == OP_MULT);

  assign div_opa    = (state_q == S_DIV_WAIT) ? opa_q : '0;
  assign div_opb    = (state_q == S_DIV_WAIT) ? opb_q : '0;
  assign div_signed = (state_q == S_DIV_WAIT) && (op_q == OP_DIV);

  assign busy = (state_q != S_IDLE);
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, hand-written corner
// sequences, and random ops checked against an arithmetic reference model.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst, op_valid, flush, ex_advance;
  logic [1:0]  op_type;
  logic [31:0] src_a, src_b;
  logic [31:0] mul_a, mul_b, div_opa, div_opb, hi_o, lo_o;
  logic        mul_signed, div_signed, div_start, div_annul, stallreq, busy;
  logic        div_ready = 1'b0;
  logic [63:0] mul_result = '0;
  logic [63:0] div_result = '0;
  logic [1:0]  hilo_we;

  int n_vec = 0;
  int n_err = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_type    (op_type),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .ex_advance (ex_advance),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_signed (mul_signed),
    .mul_result (mul_result),
    .div_opa    (div_opa),
    .div_opb    (div_opb),
    .div_signed (div_signed),
    .div_start  (div_start),
    .div_annul  (div_annul),
    .div_ready  (div_ready),
    .div_result (div_result),
    .stallreq   (stallreq),
    .busy       (busy),
    .hilo_we    (hilo_we),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  // ---------------- arithmetic helpers (plain integer maths) ----------------
  function automatic logic [63:0] do_mul(input logic [31:0] a, b, input logic sgn);
    longint p;
    if (sgn) p = longint'($signed(a)) * longint'($signed(b));
    else     p = longint'({32'b0, a}) * longint'({32'b0, b});
    return p;
  endfunction

  function automatic logic [63:0] do_div(input logic [31:0] a, b, input logic sgn);
    longint sa, sb, q, r;
    if (sgn) begin sa = longint'($signed(a)); sb = longint'($signed(b)); end
    else begin sa = longint'({32'b0, a}); sb = longint'({32'b0, b}); end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Reference: what HI/LO must hold for a given instruction.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, b);
    case (op)
      2'b00:   return do_mul(a, b, 1'b0);
      2'b01:   return do_mul(a, b, 1'b1);
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return do_div(a, b, op == 2'b11);
      end
    endcase
  endfunction

  // ---------------- unit models ----------------
  always @(posedge clk)
    if (rst) mul_result <= '0;
    else     mul_result <= do_mul(mul_a, mul_b, mul_signed);

  int div_cnt = 0;
  always @(posedge clk) begin
    if (rst || div_annul || !div_start) begin
      div_cnt   <= 0;
      div_ready <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1;
      if (div_cnt == DIV_LAT - 1) begin
        div_ready  <= 1'b1;
        div_result <= do_div(div_opa, div_opb, div_signed);
      end
    end
  end

  // ---------------- checking utilities ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mul ops"}, {mul_a, mul_b}, 64'd0);
    check({tag, " div ops"}, {div_opa, div_opb}, 64'd0);
    check({tag, " hi/lo"}, {hi_o, lo_o}, 64'd0);
    check({tag, " ctrl"},
          64'({mul_signed, div_signed, div_start, div_annul, stallreq, busy, hilo_we}), 64'd0);
  endtask

  // Issue one op, follow it through the stall, hold DONE adv_wait cycles, then write.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, b,
                        input logic [63:0] exp, input int adv_wait);
    int   cyc, exp_stall;
    logic start_seen, sgn_seen, we_in_stall, is_div, div0;
    is_div      = (op == 2'b10) || (op == 2'b11);
    div0        = is_div && (b == 32'd0);
    exp_stall   = !is_div ? MUL_LAT + 1 : (div0 ? 1 : DIV_LAT + 2);
    start_seen  = 1'b0;
    sgn_seen    = 1'b0;
    we_in_stall = 1'b0;

    op_valid = 1'b1; op_type = op; src_a = a; src_b = b; ex_advance = 1'b0;
    #1 check({tag, " accept stall"}, 64'(stallreq), 64'd1);
    tick();
    op_valid = 1'b0; op_type = 2'($urandom); src_a = $urandom; src_b = $urandom;
    #1;
    if (stallreq) sgn_seen = is_div ? div_signed : mul_signed;
    cyc = 1;
    while (stallreq && cyc < 200) begin
      if (div_start) start_seen = 1'b1;
      if (hilo_we != 2'b00) we_in_stall = 1'b1;
      cyc++;
      tick();
    end
    check({tag, " stall cycles"}, 64'(cyc), 64'(exp_stall));
    check({tag, " div_start used"}, 64'(start_seen), 64'(is_div && !div0));
    check({tag, " no write while stalled"}, 64'(we_in_stall), 64'd0);
    if (!div0) check({tag, " signed flag"}, 64'(sgn_seen), 64'(op[0]));

    for (int i = 0; i < adv_wait; i++) begin
      check({tag, " DONE hold"}, 64'({busy, stallreq, hilo_we}), 64'b1000);
      tick();
    end
    ex_advance = 1'b1;
    #1;
    check({tag, " hilo_we"}, 64'(hilo_we), 64'b11);
    check({tag, " hi/lo"}, {hi_o, lo_o}, exp);
    tick();
    ex_advance = 1'b0;
    #1 check({tag, " after write"}, 64'({busy, hilo_we}), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          adv_wait;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{2'b01, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, 0};
    vecs[1]  = '{2'b10, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 0};
    vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 0};
    vecs[3]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0};
    vecs[4]  = '{2'b11, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, 0};
    vecs[5]  = '{2'b01, 32'd2,         32'd3,         64'h0000_0000_0000_0006, 3};
    vecs[6]  = '{2'b11, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1};
    vecs[7]  = '{2'b10, 32'h8000_0000, 32'd3,         64'h0000_0002_2AAA_AAAA, 0};
    vecs[8]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2};
    vecs[9]  = '{2'b00, 32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000, 0};
    vecs[10] = '{2'b10, 32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF, 1};
    vecs[11] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0};

    rst = 1'b1; op_valid = 1'b0; flush = 1'b0; ex_advance = 1'b0;
    op_type = 2'b00; src_a = '0; src_b = '0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    #1 check_all_zero("after reset release");
    tick();

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                             vecs[i].exp, vecs[i].adv_wait);

    // Flush ten cycles into DIV_WAIT.
    op_valid = 1'b1; op_type = 2'b10; src_a = 32'd100; src_b = 32'd7;
    tick();
    op_valid = 1'b0;
    repeat (9) tick();
    check("flushdiv start held", 64'(div_start), 64'd1);
    flush = 1'b1;
    #1 check("flushdiv annul", 64'({div_annul, stallreq, hilo_we}), 64'b1000);
    tick();
    flush = 1'b0;
    #1 check("flushdiv idle", 64'({busy, div_annul, div_start, hilo_we}), 64'd0);
    tick();
    run_op("post-flush mult", 2'b01, 32'd2, 32'd3, 64'd6, 0);

    // Flush in the acceptance cycle: op is dropped.
    op_valid = 1'b1; op_type = 2'b01; src_a = 32'd4; src_b = 32'd4; flush = 1'b1;
    #1 check("accept flush stall", 64'(stallreq), 64'd0);
    tick();
    op_valid = 1'b0; flush = 1'b0;
    #1 check("accept flush busy", 64'(busy), 64'd0);

    // Flush in DONE: no HI/LO write.
    op_valid = 1'b1; op_type = 2'b11; src_a = 32'd5; src_b = 32'd0;
    tick();
    op_valid = 1'b0;
    check("div0 done at T+1", 64'({busy, stallreq, div_start}), 64'b100);
    ex_advance = 1'b1; flush = 1'b1;
    #1 check("done flush we", 64'(hilo_we), 64'd0);
    tick();
    ex_advance = 1'b0; flush = 1'b0;
    #1 check("done flush idle", 64'({busy, hilo_we}), 64'd0);

    // Reset in the middle of MUL_WAIT.
    op_valid = 1'b1; op_type = 2'b01; src_a = 32'd7; src_b = 32'd9;
    tick();
    op_valid = 1'b0;
    check("mul wait busy", 64'({busy, stallreq}), 64'b11);
    rst = 1'b1;
    tick();
    check_all_zero("mid-op reset");
    rst = 1'b0;
    ex_advance = 1'b1;
    #1 check("mid-op reset no write", 64'({busy, hilo_we}), 64'd0);
    tick();
    ex_advance = 1'b0;

    // Random ops against the reference model.
    for (int k = 0; k < 24; k++) begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      r_op = 2'($urandom_range(0, 3));
      r_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 9));
      run_op($sformatf("rand%0d", k), r_op, r_a, r_b, ref_model(r_op, r_a, r_b),
             $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
